// File: rtl/imm_pkg.sv
// Shared immediate-format codes and field widths for the immediate encoder and extender.
package imm_pkg;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmJ = 3'b010,
        ImmB = 3'b011,
        ImmU = 3'b100
    } imm_src_e;

    localparam int unsigned ImmIWidth = 12;
    localparam int unsigned ImmSWidth = 12;
    localparam int unsigned ImmBWidth = 13;
    localparam int unsigned ImmJWidth = 21;
    localparam int unsigned ImmUShift = 12;

    localparam logic [7:0] ErrCntMax = 8'hFF;

    // True when v survives truncation to a w-bit two's complement field.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
        logic signed [31:0] sh;
        sh = $signed(v) >>> (w - 1);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: overwrites the immediate-owned bits of an instruction
// word and flags values the selected format cannot represent.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  i_imm_src,
    input  logic [31:0] i_value,
    input  logic [31:0] i_base_inst,
    output logic [31:0] o_inst,
    output logic        o_range_err
);

    always_comb begin
        o_inst      = i_base_inst;
        o_range_err = 1'b0;
        case (i_imm_src)
            ImmI: begin
                o_inst[31:20] = i_value[11:0];
                o_range_err   = !fits_signed(i_value, ImmIWidth);
            end
            ImmS: begin
                o_inst[31:25] = i_value[11:5];
                o_inst[11:7]  = i_value[4:0];
                o_range_err   = !fits_signed(i_value, ImmSWidth);
            end
            ImmB: begin
                o_inst[31]    = i_value[12];
                o_inst[30:25] = i_value[10:5];
                o_inst[11:8]  = i_value[4:1];
                o_inst[7]     = i_value[11];
                o_range_err   = !fits_signed(i_value, ImmBWidth) || i_value[0];
            end
            ImmJ: begin
                o_inst[31]    = i_value[20];
                o_inst[30:21] = i_value[10:1];
                o_inst[20]    = i_value[11];
                o_inst[19:12] = i_value[19:12];
                o_range_err   = !fits_signed(i_value, ImmJWidth) || i_value[0];
            end
            ImmU: begin
                o_inst[31:12] = i_value[31:12];
                o_range_err   = (i_value[ImmUShift-1:0] != '0);
            end
            // Undefined format: base word passes through untouched.
            default: o_range_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with optional saturating error counter
// (enabled by defining IMM_ENCODER_ERRCNT_EN).
module imm_encoder
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_src,
    input  logic [31:0] value,
    input  logic [31:0] base_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        range_err,
    output logic [7:0]  err_count
);

    logic        r_s1_valid;
    logic [2:0]  r_s1_src;
    logic [31:0] r_s1_value;
    logic [31:0] r_s1_base;
    logic        r_s2_valid;
    logic [31:0] r_s2_inst;
    logic        r_s2_err;
    logic        w_advance;
    logic [31:0] w_pack_inst;
    logic        w_pack_err;

    assign w_advance = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_advance;
    assign out_valid = r_s2_valid;
    assign inst      = r_s2_inst;
    assign range_err = r_s2_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= '0;
            r_s1_value <= '0;
            r_s1_base  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_src   <= imm_src;
                r_s1_value <= value;
                r_s1_base  <= base_inst;
            end
        end
    end

    imm_pack u_imm_pack (
        .i_imm_src   (r_s1_src),
        .i_value     (r_s1_value),
        .i_base_inst (r_s1_base),
        .o_inst      (w_pack_inst),
        .o_range_err (w_pack_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_inst  <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_inst <= w_pack_inst;
                r_s2_err  <= w_pack_err;
            end
        end
    end

`ifdef IMM_ENCODER_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_s2_valid && out_ready && r_s2_err && (r_err_count != ErrCntMax)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, stall/reset sequences and
// randomized traffic against an arithmetic reference model.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_src = 3'd0;
    logic [31:0] value = 32'd0;
    logic [31:0] base_inst = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] inst;
    logic        range_err;
    logic [7:0]  err_count;

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .value     (value),
        .base_inst (base_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .range_err (range_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endfunction

    // Reference model: field placement by shift/mask, range by signed integer bounds.
    function automatic void model(input logic [2:0] src, input logic [31:0] v,
                                  input logic [31:0] b, output logic [31:0] o, output logic e);
        longint sv;
        sv = longint'($signed(v));
        case (src)
            3'd0: begin
                o = (b & 32'h000F_FFFF) | ((v & 32'h0000_0FFF) << 20);
                e = (sv < -2048) || (sv > 2047);
            end
            3'd1: begin
                o = (b & 32'h01FF_F07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
                e = (sv < -2048) || (sv > 2047);
            end
            3'd3: begin
                o = (b & 32'h01FF_F07F) | (((v >> 12) & 32'h1) << 31)
                    | (((v >> 11) & 32'h1) << 7) | (((v >> 5) & 32'h3F) << 25)
                    | (((v >> 1) & 32'hF) << 8);
                e = (sv < -4096) || (sv > 4094) || ((v & 32'h1) != 32'h0);
            end
            3'd2: begin
                o = (b & 32'h0000_0FFF) | (((v >> 20) & 32'h1) << 31)
                    | (((v >> 1) & 32'h3FF) << 21) | (((v >> 11) & 32'h1) << 20)
                    | (((v >> 12) & 32'hFF) << 12);
                e = (sv < -1048576) || (sv > 1048574) || ((v & 32'h1) != 32'h0);
            end
            3'd4: begin
                o = (b & 32'h0000_0FFF) | (v & 32'hFFFF_F000);
                e = (v & 32'h0000_0FFF) != 32'h0;
            end
            default: begin
                o = b;
                e = 1'b1;
            end
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_delivered = 0;
    int          err_model = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst = 32'd0;
    logic        prev_err = 1'b0;

    function automatic logic [7:0] exp_err_count();
`ifdef IMM_ENCODER_ERRCNT_EN
        return 8'(err_model);
`else
        return 8'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
            err_model  = 0;
        end else begin
            if (prev_stall) begin
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                check("stall_inst", inst, prev_inst);
                check("stall_range_err", {31'd0, range_err}, {31'd0, prev_err});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_result: got inst=%h with nothing outstanding", inst);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result_inst", inst, e.inst);
                    check("result_range_err", {31'd0, range_err}, {31'd0, e.err});
                    check("err_count_running", {24'd0, err_count}, {24'd0, exp_err_count()});
                    if (e.err && err_model < 255) err_model++;
                    n_delivered++;
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                model(imm_src, value, base_inst, e.inst, e.err);
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_inst  = inst;
            prev_err   = range_err;
        end
    end

    task automatic push(input logic [2:0] src, input logic [31:0] v, input logic [31:0] b);
        int t;
        in_valid  = 1'b1;
        imm_src   = src;
        value     = v;
        base_inst = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_val();
        int bnd[15] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                        1048574, 1048575, 1048576, -1048576, -1048578, 0};
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 8191)) - 4096);
            2:       return 32'(bnd[$urandom_range(0, 14)]);
            3:       return $urandom & 32'hFFFF_F000;
            4:       return 32'($signed($urandom_range(0, 4194303)) - 2097152);
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  src;
        logic [31:0] val;
        logic [31:0] base;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   lat;
        int   n0;
        logic dropped;
        logic hs;

        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0});
        vecs.push_back('{3'd1, 32'h0000_0008, 32'h0000_0023, 32'h0000_0423, 1'b0});
        vecs.push_back('{3'd3, 32'h0000_0010, 32'h0000_0063, 32'h0000_0863, 1'b0});
        vecs.push_back('{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0});
        vecs.push_back('{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1});
        vecs.push_back('{3'd3, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1});
        vecs.push_back('{3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{3'd2, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0});
        vecs.push_back('{3'd1, 32'hFFFF_F800, 32'h0000_0023, 32'h8000_0023, 1'b0});
        vecs.push_back('{3'd0, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0});
        vecs.push_back('{3'd0, 32'hFFFF_F7FF, 32'h0000_0013, 32'h7FF0_0013, 1'b1});
        vecs.push_back('{3'd3, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0});
        vecs.push_back('{3'd4, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1});
        vecs.push_back('{3'd2, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1});
        vecs.push_back('{3'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h001F_FFFF, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_inst", inst, 32'd0);
        check("reset_range_err", {31'd0, range_err}, 32'd0);
        check("reset_err_count", {24'd0, err_count}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            push(vecs[i].src, vecs[i].val, vecs[i].base);
            lat = 1;
            @(negedge clk);
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
            check($sformatf("vec%0d_range_err", i), {31'd0, range_err}, {31'd0, vecs[i].exp_err});
            @(posedge clk);
            #1;
        end
        drain();
        check("err_count_after_table", {24'd0, err_count}, {24'd0, exp_err_count()});

        // Ten back-to-back requests with a three-cycle consumer stall mid-stream.
        n0 = n_delivered;
        dropped = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) push(3'($urandom_range(0, 4)), rand_val(), $urandom);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (k < 2 && !in_ready) dropped = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_in_ready_dropped", {31'd0, dropped}, 32'd1);
        check("stall_delivered_count", 32'(n_delivered - n0), 32'd10);

        // Randomized traffic with random backpressure.
        hs = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            if (!in_valid || hs) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                imm_src   = 3'($urandom_range(0, 7));
                value     = rand_val();
                base_inst = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = in_valid && in_ready;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Enough errors to push the counter into saturation.
        for (int k = 0; k < 300; k++) push(3'd7, $urandom, $urandom);
        drain();
        check("err_count_saturated", {24'd0, err_count}, {24'd0, exp_err_count()});
`ifdef IMM_ENCODER_ERRCNT_EN
        check("err_count_is_max", {24'd0, err_count}, 32'd255);
`endif

        // Reset with two requests in flight.
        out_ready = 1'b0;
        push(3'd0, 32'h0000_0800, 32'h0000_0013);
        push(3'd3, 32'h0000_0003, 32'h0000_0063);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid_now", {31'd0, out_valid}, 32'd0);
        check("rst_err_count_now", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        check("rst_err_count_after", {24'd0, err_count}, 32'd0);
        check("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  request present.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid && in_ready.
REQ-005 SHALL have port: imm_src  input  3  immediate format: I=000, S=001, J=010, B=011, U=100.
REQ-006 SHALL have port: value  input  32  signed immediate value to encode.
REQ-007 SHALL have port: base_inst  input  32  instruction carrying opcode/rd/rs/funct fields.
REQ-008 SHALL have port: out_valid  output  1  encoded result present.
REQ-009 SHALL have port: out_ready  input  1  result consumed when out_valid && out_ready.
REQ-010 SHALL have port: inst  output  32  base_inst with immediate bit positions replaced.
REQ-011 SHALL have port: range_err  output  1  value not representable in imm_src format; valid with out_valid.
REQ-012 SHALL have port: err_count  output  8  saturating count of delivered results with range_err=1.

Function
REQ-013 SHALL clear immediate-owned bits of base_inst and insert value bits: I inst[31:20]=v[11:0]; S inst[31:25]=v[11:5], inst[11:7]=v[4:0]; B inst[31]=v[12], inst[7]=v[11], inst[30:25]=v[10:5], inst[11:8]=v[4:1]; J inst[31]=v[20], inst[30:21]=v[10:1], inst[20]=v[11], inst[19:12]=v[19:12]; U inst[31:12]=v[31:12].
REQ-014 SHALL assert range_err when: I/S value outside [-2048,2047]; B outside [-4096,4094] or v[0]=1; J outside [-1048576,1048574] or v[0]=1; U v[11:0]!=0.
REQ-015 SHALL, on an undefined imm_src (101-111), pass base_inst unchanged with range_err=1.
REQ-016 SHALL, on range error, still pack the truncated low bits per REQ-013.
REQ-017 SHALL be a 2-stage pipeline: S1 registers the accepted request, S2 registers inst/range_err; latency accept-to-out_valid = 2 cycles.
REQ-018 SHALL advance when S2 is empty or consumed; in_ready = !S1_valid || advance; full throughput of 1 result/cycle with out_ready held high.
REQ-019 SHALL hold inst, range_err, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL preserve request order; no drop, no duplication under any in_valid/out_ready pattern.
REQ-021 SHALL increment err_count on the handshake of a result with range_err=1, saturating at 255.

Reset
REQ-022 SHALL, on rst, asynchronously clear S1/S2 valid, out_valid=0, inst=0, range_err=0, err_count=0, in_ready=1 after release.
REQ-023 SHALL discard in-flight requests when rst asserts mid-operation; none emitted after release.

Configuration
REQ-024 SHALL compile the error counter only when IMM_ENCODER_ERRCNT_EN is defined; without it err_count SHALL be tied to 0, the port retained.

Structure
REQ-025 SHALL take format codes (I/S/J/B/U) and the immediate field width constants from shared package imm_pkg, also used by the immediate extender.
REQ-026 SHALL place the combinational pack and range check in sub-module imm_pack; imm_encoder owns pipeline, handshake, counter.

Verification
REQ-027 SHALL cover: I, value=0xFFFFFFFF, base=0x00000013 -> inst=0xFFF00013, range_err=0, out_valid exactly 2 cycles after accept.
REQ-028 SHALL cover: S value=8, base=0x00000023 -> 0x00000423; B value=16, base=0x00000063 -> 0x00000863; U value=0x12345000, base=0x00000037 -> 0x12345037.
REQ-029 SHALL cover: I value=2048, base=0x13 -> inst=0x80000013, range_err=1, err_count 0->1 (macro defined) / stays 0 (undefined).
REQ-030 SHALL cover: B value=3 -> range_err=1; imm_src=111, base=0xDEADBEEF -> inst=0xDEADBEEF, range_err=1.
REQ-031 SHALL cover: 10 back-to-back requests with out_ready low 3 cycles mid-stream -> in_ready drops within 2 cycles, all 10 delivered in order, outputs stable while stalled.
REQ-032 SHALL cover: rst pulse with 2 requests in flight -> out_valid=0 immediately, no stale result after release, err_count=0.
